// File: rtl/mul_unit.sv
// mul_unit: sequential radix-2 shift-add multiplier, signed or unsigned.
// One operation takes 33 cycles after acceptance: 32 add/shift iterations
// on operand magnitudes, then one cycle to apply the sign and publish hi/lo.
module mul_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0]   OP_ONE   = WIDTH'(1);
   localparam logic [2*WIDTH-1:0] PROD_ONE = (2 * WIDTH)'(1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      SIGN
   } state_t;

   state_t               state_q;
   state_t               state_d;
   logic [2*WIDTH-1:0]   acc;
   logic [2*WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]     mplier;
   logic [CNT_W-1:0]     cnt;
   logic                 neg;
   logic [WIDTH-1:0]     mag_a;
   logic [WIDTH-1:0]     mag_b;

   // The most negative operand negates to itself, which is exactly its
   // magnitude when read back as an unsigned value.
   assign mag_a = (is_signed && A[WIDTH-1]) ? (~A + OP_ONE) : A;
   assign mag_b = (is_signed && B[WIDTH-1]) ? (~B + OP_ONE) : B;

   assign busy = (state_q != IDLE);

   // State register; reset wins over any start on the same edge.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values, independent of statement order.
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic: accept in IDLE, iterate in RUN, one cycle in SIGN.
   always_comb begin
      // NOTE: default assignment first so no path leaves state_d unassigned,
      // which would otherwise infer a latch.
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (cnt == CNT_LAST) state_d = SIGN;
         SIGN:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath: latch operands, accumulate partial products, publish result.
   always_ff @(posedge clk) begin
      // NOTE: every datapath register is reset here (no memories involved),
      // so an aborted operation leaves no stale result on hi/lo.
      if (!rst_n) begin
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
         neg    <= 1'b0;
         done   <= 1'b0;
         hi     <= '0;
         lo     <= '0;
      end else begin
         done <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  mcand  <= {{WIDTH{1'b0}}, mag_a};
                  mplier <= mag_b;
                  neg    <= is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                  acc    <= '0;
                  cnt    <= '0;
               end
            end
            RUN: begin
               if (mplier[0]) acc <= acc + mcand;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + CNT_ONE;
            end
            SIGN: begin
               {hi, lo} <= neg ? (~acc + PROD_ONE) : acc;
               done     <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
